mem_bus_arbiter: RTL and testbench

Two-port arbiter and bus sequencer that shares one asynchronous-strobe byte memory (the 64 KiB array driven by active-low `oe`/`we` strobes, latching on the strobe's falling edge) between the 6809 core and a second master (DMA or debug loader).
- Each granted request is turned into a fixed four-state bus cycle with guaranteed address setup, a one-cycle strobe and registered read data.
- Each requester sees a simple req/ack handshake.

---
 rtl/mem_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter sharing one strobe-latched byte memory through a fixed four-state bus cycle.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module mem_bus_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          cpu_clk,
  input  logic          cpu_reset,
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_data_i,
  output logic          a_ack_o,
  output logic [DW-1:0] a_data_o,
  output logic          a_gnt_o,
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_data_i,
  output logic          b_ack_o,
  output logic [DW-1:0] b_data_o,
  output logic          b_gnt_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          mem_oe_n_o,
  output logic          mem_we_n_o
);

  // state  | meaning
  // IDLE   | sample requests, latch winner's command
  // ADDR   | address/data setup, strobes high
  // STROBE | one strobe low for one cycle
  // DONE   | strobes high, ack pulse, read data presented
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] r_state;
  logic       r_we;
  logic       r_owner_b;
  logic       w_sel_b;

`ifdef MEM_ARB_RR_EN
  logic r_last_b;

  always_comb begin
    w_sel_b = b_req_i & ~a_req_i;
    if (a_req_i && b_req_i) w_sel_b = ~r_last_b;
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset)
      r_last_b <= 1'b1;
    else if (r_state == S_IDLE && (a_req_i || b_req_i))
      r_last_b <= w_sel_b;
  end
`else
  always_comb begin
    w_sel_b = b_req_i & ~a_req_i;
  end
`endif

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_owner_b  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_oe_n_o <= 1'b1;
      mem_we_n_o <= 1'b1;
      a_ack_o    <= 1'b0;
      b_ack_o    <= 1'b0;
      a_gnt_o    <= 1'b0;
      b_gnt_o    <= 1'b0;
      a_data_o   <= '0;
      b_data_o   <= '0;
    end else begin
      a_ack_o <= 1'b0;
      b_ack_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (a_req_i || b_req_i) begin
            r_owner_b  <= w_sel_b;
            r_we       <= w_sel_b ? b_we_i   : a_we_i;
            mem_addr_o <= w_sel_b ? b_addr_i : a_addr_i;
            mem_data_o <= w_sel_b ? b_data_i : a_data_i;
            a_gnt_o    <= ~w_sel_b;
            b_gnt_o    <= w_sel_b;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (r_we) mem_we_n_o <= 1'b0;
          else      mem_oe_n_o <= 1'b0;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          mem_oe_n_o <= 1'b1;
          mem_we_n_o <= 1'b1;
          // memory latched on the strobe's falling edge, so read data has been stable all cycle
          if (!r_we) begin
            if (r_owner_b) b_data_o <= mem_data_i;
            else           a_data_o <= mem_data_i;
          end
          if (r_owner_b) b_ack_o <= 1'b1;
          else           a_ack_o <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          a_gnt_o <= 1'b0;
          b_gnt_o <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a strobe-latched memory model.
// Contention expectations follow the MEM_ARB_RR_EN setting of the build.
module tb_mem_bus_arbiter;

  logic        cpu_clk;
  logic        cpu_reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic        a_ack_o, a_gnt_o, b_ack_o, b_gnt_o;
  logic [7:0]  a_data_o, b_data_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o, mem_data_i;
  logic        mem_oe_n_o, mem_we_n_o;

  logic [7:0]  mem [0:65535];
  logic [7:0]  mem_rd;

  int checks = 0;
  int errors = 0;
  int bad_gnt = 0, bad_strobe = 0, oe_low = 0, we_low = 0;

  mem_bus_arbiter #(.AW(16), .DW(8)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_ack_o(a_ack_o), .a_data_o(a_data_o), .a_gnt_o(a_gnt_o),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_ack_o(b_ack_o), .b_data_o(b_data_o), .b_gnt_o(b_gnt_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_oe_n_o(mem_oe_n_o), .mem_we_n_o(mem_we_n_o)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // memory latches on the falling edge of either strobe
  always @(negedge mem_oe_n_o) mem_rd = mem[mem_addr_o];
  always @(negedge mem_we_n_o) mem[mem_addr_o] = mem_data_o;
  assign mem_data_i = mem_rd;

  always @(negedge cpu_clk) begin
    if (a_gnt_o && b_gnt_o) bad_gnt++;
    if (!mem_oe_n_o && !mem_we_n_o) bad_strobe++;
    if (!mem_oe_n_o) oe_low++;
    if (!mem_we_n_o) we_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // drive one command, wait (bounded) for its ack, then return to IDLE
  task automatic txn(input bit pb, input bit we, input logic [15:0] addr,
                     input logic [7:0] wd, input string tag);
    int lat;
    lat = 0;
    if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_data = wd; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_data = wd; end
    do begin step(); lat++; end while (!(pb ? b_ack_o : a_ack_o) && lat < 10);
    if (pb) b_req = 0; else a_req = 0;
    chk({tag, "_lat"}, lat, 3);
    step();
  endtask

  task automatic wait_ack(output int n, output bit who_b);
    n = 0;
    do begin step(); n++; end while (!(a_ack_o || b_ack_o) && n < 12);
    who_b = b_ack_o;
  endtask

  int oe0, we0, n;
  bit who;

  initial begin
    mem[16'h1000] = 8'h8E;
    cpu_reset = 1; a_req = 0; a_we = 0; a_addr = 0; a_data = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_data = 0;
    step(); step();
    chk("rst_oe_n", mem_oe_n_o, 1);
    chk("rst_we_n", mem_we_n_o, 1);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_data_o, 0);
    chk("rst_acks", {a_ack_o, b_ack_o}, 0);
    chk("rst_gnts", {a_gnt_o, b_gnt_o}, 0);
    chk("rst_rdata", {a_data_o, b_data_o}, 0);
    cpu_reset = 0;
    step();

    // port A read of 0x1000
    oe0 = oe_low; we0 = we_low;
    a_req = 1; a_we = 0; a_addr = 16'h1000; a_data = 8'h00;
    step();
    chk("ard_gnt", {a_gnt_o, b_gnt_o}, 2'b10);
    chk("ard_addr", mem_addr_o, 16'h1000);
    chk("ard_setup_oe", mem_oe_n_o, 1);
    step();
    chk("ard_strobe_oe", mem_oe_n_o, 0);
    chk("ard_strobe_ack", a_ack_o, 0);
    step();
    chk("ard_done_oe", mem_oe_n_o, 1);
    chk("ard_ack", a_ack_o, 1);
    chk("ard_data", a_data_o, 8'h8E);
    a_req = 0;
    step();
    chk("ard_ack_pulse", a_ack_o, 0);
    chk("ard_gnt_clr", a_gnt_o, 0);
    chk("ard_oe_cycles", oe_low - oe0, 1);
    chk("ard_we_cycles", we_low - we0, 0);

    // port B write of 0x55 to 0x0102
    oe0 = oe_low; we0 = we_low;
    b_req = 1; b_we = 1; b_addr = 16'h0102; b_data = 8'h55;
    step();
    chk("bwr_gnt", {a_gnt_o, b_gnt_o}, 2'b01);
    chk("bwr_addr", mem_addr_o, 16'h0102);
    chk("bwr_wdata", mem_data_o, 8'h55);
    chk("bwr_setup_we", mem_we_n_o, 1);
    step();
    chk("bwr_strobe_we", mem_we_n_o, 0);
    chk("bwr_strobe_addr", mem_addr_o, 16'h0102);
    step();
    chk("bwr_ack", b_ack_o, 1);
    chk("bwr_done_we", mem_we_n_o, 1);
    chk("bwr_rdata_kept", b_data_o, 8'h00);
    chk("bwr_mem", mem[16'h0102], 8'h55);
    b_req = 0;
    step();
    chk("bwr_ack_pulse", b_ack_o, 0);
    chk("bwr_we_cycles", we_low - we0, 1);
    chk("bwr_oe_cycles", oe_low - oe0, 0);

    // top-of-memory address passes through unmodified
    txn(0, 1, 16'hFFFF, 8'hAA, "a_wr_ffff");
    chk("ffff_mem", mem[16'hFFFF], 8'hAA);
    chk("ffff_a_kept", a_data_o, 8'h8E);
    txn(1, 0, 16'hFFFF, 8'h00, "b_rd_ffff");
    chk("ffff_b_data", b_data_o, 8'hAA);

    // contention: B was served last, so A wins the first slot in either mode
    a_req = 1; a_we = 0; a_addr = 16'h1000;
    b_req = 1; b_we = 0; b_addr = 16'h0102;
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, who);
      chk("rr_who", who, i % 2);
      chk("rr_gap", n, (i == 0) ? 3 : 4);
    end
    a_req = 0; b_req = 0;
    step();
`else
    for (int i = 0; i < 3; i++) begin
      wait_ack(n, who);
      chk("fp_who", who, 0);
      chk("fp_gap", n, (i == 0) ? 3 : 4);
    end
    a_req = 0;
    wait_ack(n, who);
    chk("fp_b_who", who, 1);
    chk("fp_b_gap", n, 4);
    b_req = 0;
    step();
`endif
    chk("cont_b_data", b_data_o, 8'h55);
    chk("cont_a_data", a_data_o, 8'h8E);

    // asynchronous reset in the middle of a read strobe
    a_req = 1; a_we = 0; a_addr = 16'h0102;
    step();
    step();
    chk("mid_strobe_oe", mem_oe_n_o, 0);
    #2 cpu_reset = 1;
    #1;
    chk("mid_rst_oe_n", mem_oe_n_o, 1);
    chk("mid_rst_gnt", a_gnt_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_rdata", a_data_o, 0);
    a_req = 0;
    step();
    chk("mid_rst_no_ack", {a_ack_o, b_ack_o}, 0);
    cpu_reset = 0;
    step();
    chk("post_rst_no_ack", {a_ack_o, b_ack_o}, 0);
    txn(0, 0, 16'h0102, 8'h00, "post_rst_rd");
    chk("post_rst_data", a_data_o, 8'h55);

    chk("never_both_gnt", bad_gnt, 0);
    chk("never_both_strobe", bad_strobe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
